lockstep_compare: RTL
=====================

# lockstep_compare

Synthesizable lockstep checker: the consuming end of the RTL-vs-TLV equivalence harness used for the basic_logic patterns. Takes the outputs of two DUT instances driven by the same stimulus and compares them on every qualified cycle inside a start/stop window. Counts samples and mismatches, and reports a registered pass/fail verdict. Lets equivalence checks run in hardware (FPGA, emulation) or in benches that carry no behavioural checking code.

## Interface
- WIDTH, 4: width of each compared DUT output
- CNT_W, 16: width of sample/error counters and captured index
- SKIP, 2: cycles ignored after start, so DUTs can settle from reset; 0 allowed
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; opens a comparison window
- stop  in  1  pulse; closes the window
- valid  in  1  sample qualifier; compare only when high
- a  in  WIDTH  output of DUT A (RTL)
- b  in  WIDTH  output of DUT B (TLV)
- busy  out  1  high in SKIP or RUN
- done  out  1  high in DONE
- pass  out  1  verdict; meaningful only while done=1
- sample_count  out  CNT_W  qualified samples compared in the window
- err_count  out  CNT_W  mismatching samples in the window
- first_valid  out  1  a mismatch has been captured (LOCKSTEP_CAPTURE_EN only)
- first_idx  out  CNT_W  sample index of the first mismatch (LOCKSTEP_CAPTURE_EN only)
- first_a, first_b  out  WIDTH  a and b values at the first mismatch (LOCKSTEP_CAPTURE_EN only)

## Operation
- FSM states: IDLE, SKIP, RUN, DONE.
- Reset values: state IDLE; all outputs 0; internal skip counter 0.
- IDLE: start → SKIP. Counters and capture registers clear on the same edge. SKIP=0 goes straight to RUN. stop is ignored.
- SKIP: the counter advances every cycle, independent of valid. Enter RUN after exactly SKIP cycles. stop → DONE with sample_count=0. start is ignored.
- RUN: on each cycle with valid=1:
  - sample_count increments.
  - If a != b, err_count increments.
  - Both counters saturate at all-ones and never wrap.
  - valid=0 cycles change nothing.
- stop in RUN → DONE. The stop cycle is inclusive: a valid sample in that cycle is counted.
- start in RUN is ignored. There is no restart without passing through DONE.
- DONE: counters hold.
  - pass = (err_count==0) && (sample_count!=0). An empty window fails.
  - start → SKIP and clears everything, as from IDLE. stop is ignored.
- start and stop in the same cycle: start wins in IDLE/DONE; stop wins in SKIP/RUN.
- rst_n low in any state → immediate return to IDLE with reset values. No verdict survives.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- A sample at edge N is reflected in the counters after edge N.
- busy rises on the edge that samples start. done rises, and busy falls, on the edge that samples stop.
- pass is valid the same cycle done rises. pass is 0 whenever done=0.
- Counter clear on start and first sample accumulation never coincide: the cycle that samples start is never compared, even with SKIP=0.

## Configuration
- Macro: LOCKSTEP_CAPTURE_EN.
- Defined:
  - On the first mismatching sample of a window, capture sample_count's pre-increment value into first_idx (0-based), and capture a and b into first_a and first_b.
  - Set first_valid.
  - Later mismatches do not overwrite the capture.
  - The capture clears on start and on reset.
- Undefined: first_valid, first_idx, first_a and first_b are tied to 0, and no capture registers are built.

## Test plan
- Identical streams, SKIP=2, WIDTH=4: start, 2 cycles, 8 valid samples with a=b=0xA,0x5,…, stop → done=1, pass=1, sample_count=8, err_count=0.
- Single fault: 6 valid samples with the 4th a=0xF, b=0x5, stop → pass=0, err_count=1, sample_count=6. With capture enabled: first_valid=1, first_idx=3, first_a=0xF, first_b=0x5. A second fault at sample 5 leaves the capture unchanged.
- Qualifier, skip and edge cases:
  - Mismatch presented during SKIP is not counted.
  - valid=0 cycles carrying a≠b are not counted.
  - A valid sample in the stop cycle is counted.
  - stop during SKIP → done=1, pass=0, sample_count=0.
- Saturation: CNT_W=4, 20 mismatching valid samples → err_count=sample_count=0xF, no wrap. Then start from DONE → counters 0, busy=1, done=0.
- Reset mid-RUN: assert rst_n=0 asynchronously between edges → busy/done/pass/counters read 0 immediately. A later stop is ignored until a new start.
- Simultaneous start+stop in IDLE → enters SKIP (busy=1). Start+stop in RUN → DONE.

Source files
------------

// File: rtl/lockstep_if.sv
// lockstep_if: stimulus, sampled DUT outputs and verdict/counter signals of the lockstep checker.
interface lockstep_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
);
    logic             start;
    logic             stop;
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] sample_count;
    logic [CNT_W-1:0] err_count;
    logic             first_valid;
    logic [CNT_W-1:0] first_idx;
    logic [WIDTH-1:0] first_a;
    logic [WIDTH-1:0] first_b;

    modport master (
        output start, stop, valid, a, b,
        input  busy, done, pass, sample_count, err_count, first_valid, first_idx, first_a, first_b
    );

    modport slave (
        input  start, stop, valid, a, b,
        output busy, done, pass, sample_count, err_count, first_valid, first_idx, first_a, first_b
    );
endinterface

// File: rtl/lockstep_compare.sv
// lockstep_compare: windowed a-vs-b comparator with saturating sample/error counters and registered verdict.
// Define LOCKSTEP_CAPTURE_EN to capture index and values of the first mismatch in each window.
module lockstep_compare #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16,
    parameter int SKIP  = 2
) (
    input logic       clk,
    input logic       rst_n,
    lockstep_if.slave bus
);
    localparam int SW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SKIP, S_RUN, S_DONE} state_t;

    state_t           state, state_n;
    logic [SW-1:0]    skip_cnt, skip_n;
    logic [CNT_W-1:0] samp, samp_n, err, err_n;
    logic             busy, done, pass, clr;

    always_comb begin
        state_n = state;
        skip_n  = skip_cnt;
        samp_n  = samp;
        err_n   = err;
        clr     = 1'b0;
        case (state)
            S_IDLE, S_DONE: if (bus.start) begin
                state_n = (SKIP == 0) ? S_RUN : S_SKIP;
                skip_n  = '0;
                samp_n  = '0;
                err_n   = '0;
                clr     = 1'b1;
            end
            S_SKIP: begin
                skip_n  = skip_cnt + 1'b1;
                state_n = bus.stop ? S_DONE : (int'(skip_cnt) == SKIP - 1) ? S_RUN : S_SKIP;
            end
            default: begin
                if (bus.valid) begin
                    samp_n = &samp ? samp : samp + 1'b1;
                    err_n  = (bus.a == bus.b || &err) ? err : err + 1'b1;
                end
                state_n = bus.stop ? S_DONE : S_RUN;
            end
        endcase
    end

    // Flags are computed from next-state values so every output is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            skip_cnt <= '0;
            samp     <= '0;
            err      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            state    <= state_n;
            skip_cnt <= skip_n;
            samp     <= samp_n;
            err      <= err_n;
            busy     <= state_n == S_SKIP || state_n == S_RUN;
            done     <= state_n == S_DONE;
            pass     <= state_n == S_DONE && err_n == '0 && samp_n != '0;
        end
    end

    assign bus.busy         = busy;
    assign bus.done         = done;
    assign bus.pass         = pass;
    assign bus.sample_count = samp;
    assign bus.err_count    = err;

`ifdef LOCKSTEP_CAPTURE_EN
    logic             cap_v;
    logic [CNT_W-1:0] cap_idx;
    logic [WIDTH-1:0] cap_a, cap_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_v   <= 1'b0;
            cap_idx <= '0;
            cap_a   <= '0;
            cap_b   <= '0;
        end else if (clr) begin
            cap_v   <= 1'b0;
            cap_idx <= '0;
            cap_a   <= '0;
            cap_b   <= '0;
        end else if (state == S_RUN && bus.valid && bus.a != bus.b && !cap_v) begin
            cap_v   <= 1'b1;
            cap_idx <= samp;
            cap_a   <= bus.a;
            cap_b   <= bus.b;
        end
    end

    assign bus.first_valid = cap_v;
    assign bus.first_idx   = cap_idx;
    assign bus.first_a     = cap_a;
    assign bus.first_b     = cap_b;
`else
    assign bus.first_valid = 1'b0;
    assign bus.first_idx   = '0;
    assign bus.first_a     = '0;
    assign bus.first_b     = '0;
`endif
endmodule
